bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential BCD-to-binary converter (reverse double-dabble): accepts a packed multi-digit BCD value and produces its unsigned binary equivalent, one shift/adjust step per enabled clock. Sits on the oscilloscope's front-panel/command path, turning operator-entered decimal settings (timebase, trigger level, offsets) into binary values for the acquisition and computation blocks. It is the inverse of the existing binary-to-BCD display converter and shares its start/done/clock-enable handshake.

## Interface
- BCD_DIGITS_IN_PP, 5, number of BCD digits on the input
- BITS_OUT_PP, 17, binary output width; must satisfy 2^BITS_OUT_PP > 10^BCD_DIGITS_IN_PP - 1
- BIT_COUNT_WIDTH_PP, 5, step-counter width; must hold BITS_OUT_PP-1
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- ce_i  input  1  clock enable for conversion steps only
- start_i  input  1  request conversion; sampled only while idle
- dat_bcd_i  input  4*BCD_DIGITS_IN_PP  packed BCD, digit 0 in bits [3:0]
- dat_binary_o  output  BITS_OUT_PP  registered result, held until next completion
- done_o  output  1  high when idle (result valid after a conversion)
- err_o  output  1  invalid-digit flag (see Configuration)

## Operation
- States: IDLE (busy=0) and BUSY (busy=1); done_o = ~busy.
- IDLE, start_i=1: capture dat_bcd_i into bcd_reg, clear bin_reg and step counter, go BUSY. ce_i not required for capture.
- BUSY, ce_i=1, per step: {bcd_reg, bin_reg} shifted right one bit (bcd_reg[0] enters bin_reg MSB); then each 4-bit digit of bcd_reg >= 8 has 3 subtracted (mod-16). Counter increments.
- Step BITS_OUT_PP (counter == BITS_OUT_PP-1 with ce_i=1): perform the step, load dat_binary_o with the post-shift bin_reg, return to IDLE.
- BUSY, ce_i=0: all state holds.
- start_i while BUSY: ignored, no restart, no queueing.
- start_i held high across completion: new capture on first IDLE cycle (one cycle of done_o=1 minimum).
- Arithmetic: unsigned only; no rounding; BCD residue after the final step is zero for all valid inputs and is discarded.

## Timing
- Reset (async assert, sync-safe release): busy=0, done_o=1, dat_binary_o=0, err_o=0, bcd_reg/bin_reg/counter=0.
- Reset during BUSY: conversion aborted immediately, outputs return to reset values; no partial result.
- Latency with ce_i constantly high: capture edge E0, steps on E1..E_BITS_OUT_PP; done_o rises and dat_binary_o updates together after E_BITS_OUT_PP (17 cycles default).
- With ce_i gating: latency = 1 + BITS_OUT_PP enabled cycles.
- dat_binary_o changes only on completion edges or reset.

## Configuration
- BCD_TO_BINARY_CHECK_EN defined: at capture, any digit > 9 latches an internal error bit; conversion runs for full latency; on completion err_o=1 and dat_binary_o=0. err_o cleared at next capture.
- Not defined: no digit checking; err_o tied 0; invalid digits yield an unspecified but deterministic result.

## Structure
- Shared package: BCD digit width constant (4), digit adjust threshold (8) and correction (3), state encoding constants for IDLE/BUSY, helper for required output width given digit count.
- One sub-module natural: bcd_digit_adjust — combinational 4-bit digit, output digit-3 if >=8 else digit; instantiated BCD_DIGITS_IN_PP times. Optional digit-validity compare lives in the same sub-module behind the macro.

## Test plan
- dat_bcd_i=20'h00012, start, ce_i=1 -> done_o low 17 cycles, then dat_binary_o=17'd12, done_o=1.
- dat_bcd_i=20'h99999 -> dat_binary_o=17'h1869F; dat_bcd_i=20'h00000 -> 17'h0; 20'h65535 -> 17'h0FFFF.
- ce_i toggled 1/0 every cycle during 20'h04096 -> completes after 17 enabled cycles (~34 clocks), dat_binary_o=17'd4096, value unchanged on disabled cycles.
- start_i pulsed again mid-conversion with different input -> ignored; first result delivered at normal latency.
- rst_i asserted at step 8 of 20'h54321 -> done_o=1, dat_binary_o=0 immediately (no clock needed); fresh start then yields 17'd54321.
- With BCD_TO_BINARY_CHECK_EN: 20'h0000A -> err_o=1, dat_binary_o=0 at completion; next start with 20'h00010 -> err_o=0, dat_binary_o=17'd10.

Source files
------------

// File: rtl/bcd_to_binary_pkg.sv
// bcd_to_binary_pkg: shared constants, state encoding and width helper for the BCD-to-binary converter.
package bcd_to_binary_pkg;
    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_CORR   = 4'd3;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    // Smallest binary width able to hold 10^digits - 1.
    function automatic int bits_for_digits(input int digits);
        longint unsigned v = 1;
        for (int k = 0; k < digits; k++) v = v * 10;
        return $clog2(v);
    endfunction
endpackage

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: start/done/clock-enable handshake and data bus of the BCD-to-binary converter.
interface bcd_to_binary_if #(
    parameter int BCD_DIGITS_IN_PP = 5,
    parameter int BITS_OUT_PP      = 17
);
    logic                          ce_i;
    logic                          start_i;
    logic [4*BCD_DIGITS_IN_PP-1:0] dat_bcd_i;
    logic [BITS_OUT_PP-1:0]        dat_binary_o;
    logic                          done_o;
    logic                          err_o;

    modport master (output ce_i, start_i, dat_bcd_i, input dat_binary_o, done_o, err_o);
    modport slave  (input ce_i, start_i, dat_bcd_i, output dat_binary_o, done_o, err_o);
endinterface

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: per-digit reverse double-dabble correction (subtract 3 when >= 8).
// With BCD_TO_BINARY_CHECK_EN defined it also flags a raw digit above 9.
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [DIGIT_W-1:0] dig_i,
    output logic [DIGIT_W-1:0] dig_o
`ifdef BCD_TO_BINARY_CHECK_EN
    ,
    input  logic [DIGIT_W-1:0] chk_i,
    output logic               bad_o
`endif
);
    assign dig_o = dig_i >= ADJ_THRESH ? dig_i - ADJ_CORR : dig_i;
`ifdef BCD_TO_BINARY_CHECK_EN
    assign bad_o = chk_i > DIGIT_MAX;
`endif
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential packed-BCD to unsigned binary converter, one shift/adjust step per enabled clock.
// Optional invalid-digit detection is built when BCD_TO_BINARY_CHECK_EN is defined.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int BCD_DIGITS_IN_PP   = 5,
    parameter int BITS_OUT_PP        = 17,
    parameter int BIT_COUNT_WIDTH_PP = 5
) (
    input logic             clk_i,
    input logic             rst_i,
    bcd_to_binary_if.slave  s_if
);
    localparam int BCD_W = DIGIT_W * BCD_DIGITS_IN_PP;
    localparam logic [BIT_COUNT_WIDTH_PP-1:0] LAST = BIT_COUNT_WIDTH_PP'(BITS_OUT_PP - 1);

    state_e                        state_q, state_d;
    logic [BCD_W-1:0]              bcd_q, bcd_d, bcd_sh, bcd_adj;
    logic [BITS_OUT_PP-1:0]        bin_q, bin_d, bin_sh, res_q, res_d;
    logic [BIT_COUNT_WIDTH_PP-1:0] cnt_q, cnt_d;
    logic                          bad_q, bad_d, err_q, err_d;
    logic                          cap, stp, fin, cap_bad;

    // {bcd, bin} shifted right as one word; the BCD LSB enters the binary MSB.
    assign bcd_sh = bcd_q >> 1;
    assign bin_sh = {bcd_q[0], bin_q[BITS_OUT_PP-1:1]};

`ifdef BCD_TO_BINARY_CHECK_EN
    logic [BCD_DIGITS_IN_PP-1:0] dig_bad;
    for (genvar i = 0; i < BCD_DIGITS_IN_PP; i++) begin : g_dig
        bcd_digit_adjust u_adj (
            .dig_i (bcd_sh[i*DIGIT_W +: DIGIT_W]),
            .dig_o (bcd_adj[i*DIGIT_W +: DIGIT_W]),
            .chk_i (s_if.dat_bcd_i[i*DIGIT_W +: DIGIT_W]),
            .bad_o (dig_bad[i])
        );
    end
    assign cap_bad = |dig_bad;
`else
    for (genvar i = 0; i < BCD_DIGITS_IN_PP; i++) begin : g_dig
        bcd_digit_adjust u_adj (
            .dig_i (bcd_sh[i*DIGIT_W +: DIGIT_W]),
            .dig_o (bcd_adj[i*DIGIT_W +: DIGIT_W])
        );
    end
    assign cap_bad = 1'b0;
`endif

    assign cap = state_q == IDLE && s_if.start_i;
    assign stp = state_q == BUSY && s_if.ce_i;
    assign fin = stp && cnt_q == LAST;

    always_comb begin
        state_d = cap ? BUSY : fin ? IDLE : state_q;
        bcd_d   = cap ? s_if.dat_bcd_i : stp ? bcd_adj : bcd_q;
        bin_d   = cap ? '0 : stp ? bin_sh : bin_q;
        cnt_d   = cap ? '0 : stp ? cnt_q + 1'b1 : cnt_q;
        bad_d   = cap ? cap_bad : bad_q;
        err_d   = cap ? 1'b0 : fin ? bad_q : err_q;
        res_d   = fin ? (bad_q ? '0 : bin_sh) : res_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    assign s_if.dat_binary_o = res_q;
    assign s_if.done_o       = state_q == IDLE;
    assign s_if.err_o        = err_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized self-checking bench for bcd_to_binary against a decimal-arithmetic model.
module tb_bcd_to_binary;
    localparam int N = 5;
    localparam int B = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bcd_to_binary_if #(.BCD_DIGITS_IN_PP(N), .BITS_OUT_PP(B)) bus ();

    bcd_to_binary #(.BCD_DIGITS_IN_PP(N), .BITS_OUT_PP(B), .BIT_COUNT_WIDTH_PP(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .s_if  (bus)
    );

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int k = 0; k < N; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [4*N-1:0] b);
        int r = 0;
        int m = 1;
        for (int k = 0; k < N; k++) begin
            r += int'(b[4*k +: 4]) * m;
            m *= 10;
        end
        return r;
    endfunction

    // Start a conversion and wait (bounded) for done; reports edges after capture and whether the result moved while busy.
    task automatic run(input logic [4*N-1:0] bcd, input bit toggle, output int cyc, output bit moved);
        logic [B-1:0] prev;
        bus.dat_bcd_i = bcd;
        bus.start_i = 1'b1;
        bus.ce_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.ce_i = !toggle;
        cyc = 0;
        moved = 1'b0;
        prev = bus.dat_binary_o;
        while (bus.done_o !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (toggle) bus.ce_i = ~bus.ce_i;
            if (bus.done_o !== 1'b1 && bus.dat_binary_o !== prev) moved = 1'b1;
        end
        bus.ce_i = 1'b1;
    endtask

    task automatic test_reset;
        bus.ce_i = 1'b0;
        bus.start_i = 1'b0;
        bus.dat_bcd_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL reset_done: got %b want 1", bus.done_o); end
        n_chk++; if (bus.dat_binary_o !== '0) begin n_fail++; $display("FAIL reset_dat: got %0d want 0", bus.dat_binary_o); end
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_done: got %b want 1", bus.done_o); end
    endtask

    task automatic test_basic;
        int cyc;
        bit mv;
        run(20'h00012, 1'b0, cyc, mv);
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL basic_latency: got %0d want 17", cyc); end
        n_chk++; if (bus.dat_binary_o !== B'(12)) begin n_fail++; $display("FAIL basic_value: got %0d want 12", bus.dat_binary_o); end
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", bus.err_o); end
        n_chk++; if (mv) begin n_fail++; $display("FAIL basic_hold: result changed while busy"); end
    endtask

    task automatic test_vectors;
        logic [4*N-1:0] vec [3] = '{20'h99999, 20'h00000, 20'h65535};
        int cyc;
        bit mv;
        for (int k = 0; k < 3; k++) begin
            run(vec[k], 1'b0, cyc, mv);
            n_chk++; if (bus.dat_binary_o !== B'(from_bcd(vec[k]))) begin n_fail++; $display("FAIL vector_%h: got %h want %h", vec[k], bus.dat_binary_o, B'(from_bcd(vec[k]))); end
            n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL vector_latency_%h: got %0d want 17", vec[k], cyc); end
        end
    endtask

    task automatic test_random;
        int v, cyc;
        bit mv;
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 99999));
            run(to_bcd(v), k[0], cyc, mv);
            n_chk++; if (bus.dat_binary_o !== B'(v)) begin n_fail++; $display("FAIL random_%0d: got %0d want %0d", k, bus.dat_binary_o, v); end
            n_chk++; if (cyc != (k[0] ? 34 : 17)) begin n_fail++; $display("FAIL random_latency_%0d: got %0d want %0d", k, cyc, k[0] ? 34 : 17); end
        end
    endtask

    task automatic test_ce_gating;
        int cyc;
        bit mv;
        run(20'h04096, 1'b1, cyc, mv);
        n_chk++; if (cyc != 34) begin n_fail++; $display("FAIL ce_latency: got %0d want 34", cyc); end
        n_chk++; if (bus.dat_binary_o !== B'(4096)) begin n_fail++; $display("FAIL ce_value: got %0d want 4096", bus.dat_binary_o); end
        n_chk++; if (mv) begin n_fail++; $display("FAIL ce_hold: result changed while busy"); end
    endtask

    task automatic test_restart_ignored;
        int cyc = 0;
        bus.dat_bcd_i = 20'h00777;
        bus.start_i = 1'b1;
        bus.ce_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        while (bus.done_o !== 1'b1 && cyc < 200) begin
            if (cyc == 5) begin bus.dat_bcd_i = 20'h99999; bus.start_i = 1'b1; end
            @(posedge clk); #1;
            cyc++;
            bus.start_i = 1'b0;
        end
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL restart_latency: got %0d want 17", cyc); end
        n_chk++; if (bus.dat_binary_o !== B'(777)) begin n_fail++; $display("FAIL restart_value: got %0d want 777", bus.dat_binary_o); end
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        bus.dat_bcd_i = 20'h00321;
        bus.start_i = 1'b1;
        bus.ce_i = 1'b1;
        @(posedge clk); #1;
        bus.dat_bcd_i = 20'h00654;
        while (bus.done_o !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 17", cyc); end
        n_chk++; if (bus.dat_binary_o !== B'(321)) begin n_fail++; $display("FAIL b2b_first_value: got %0d want 321", bus.dat_binary_o); end
        @(posedge clk); #1;
        n_chk++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_recapture: got done %b want 0", bus.done_o); end
        bus.start_i = 1'b0;
        cyc = 0;
        while (bus.done_o !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 17", cyc); end
        n_chk++; if (bus.dat_binary_o !== B'(654)) begin n_fail++; $display("FAIL b2b_second_value: got %0d want 654", bus.dat_binary_o); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit mv;
        bus.dat_bcd_i = 20'h54321;
        bus.start_i = 1'b1;
        bus.ce_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        n_chk++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b want 1", bus.done_o); end
        n_chk++; if (bus.dat_binary_o !== '0) begin n_fail++; $display("FAIL midrst_dat: got %0d want 0", bus.dat_binary_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        run(20'h54321, 1'b0, cyc, mv);
        n_chk++; if (bus.dat_binary_o !== B'(54321)) begin n_fail++; $display("FAIL midrst_fresh: got %0d want 54321", bus.dat_binary_o); end
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL midrst_latency: got %0d want 17", cyc); end
    endtask

    task automatic test_check;
        int cyc;
        bit mv;
        run(20'h0000A, 1'b0, cyc, mv);
`ifdef BCD_TO_BINARY_CHECK_EN
        n_chk++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL check_err_set: got %b want 1", bus.err_o); end
        n_chk++; if (bus.dat_binary_o !== '0) begin n_fail++; $display("FAIL check_dat_zero: got %0d want 0", bus.dat_binary_o); end
`else
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL nocheck_err: got %b want 0", bus.err_o); end
`endif
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL check_latency: got %0d want 17", cyc); end
        run(20'h00010, 1'b0, cyc, mv);
        n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL check_err_clear: got %b want 0", bus.err_o); end
        n_chk++; if (bus.dat_binary_o !== B'(10)) begin n_fail++; $display("FAIL check_next_value: got %0d want 10", bus.dat_binary_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_random();
        test_ce_gating();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
